// File: rtl/lab6_pkg.sv
// lab6_pkg: shared types and defaults for the lab6 filter sequencing controller.
//   state_e     controller states IDLE/ISSUE/DRAIN/DONE
//   NTAPS_DEF   default coefficient tap count
//   MULT_LAT_DEF default multiplier latency
//   coef_t / samp_t  datapath coefficient (12b) and sample (10b) words
package lab6_pkg;

  localparam int unsigned NTAPS_DEF    = 3;
  localparam int unsigned MULT_LAT_DEF = 1;
  localparam int unsigned COEF_W       = 12;
  localparam int unsigned SAMP_W       = 10;

  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [SAMP_W-1:0] samp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/lab6_vpipe.sv
// lab6_vpipe: product-valid pipeline. Delays {valid, first} by MULT_LAT cycles
// so accumulate enables line up with the multiplier output.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   i_vld, i_first    operand issued this cycle / operand is tap 0
//   o_acc_en          product valid at accumulator this cycle
//   o_acc_clr         that product is tap 0 (load instead of add)
//   o_tail_empty      no valid entries behind the output stage
module lab6_vpipe
  import lab6_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_vld,
  input  logic i_first,
  output logic o_acc_en,
  output logic o_acc_clr,
  output logic o_tail_empty
);

  logic [MULT_LAT-1:0] r_vld;
  logic [MULT_LAT-1:0] r_fst;

  // Shift in at bit 0; truncating the concatenation drops the oldest entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld <= '0;
      r_fst <= '0;
    end else begin
      r_vld <= MULT_LAT'({r_vld, i_vld});
      r_fst <= MULT_LAT'({r_fst, i_first});
    end
  end

  assign o_acc_en     = r_vld[MULT_LAT-1];
  assign o_acc_clr    = r_fst[MULT_LAT-1];
  // Everything except the output stage is empty once the shifted-out view is zero.
  assign o_tail_empty = (MULT_LAT'(r_vld << 1) == '0);

endmodule

// File: rtl/lab6_ctrl.sv
// lab6_ctrl: sequencing controller for a shared-multiplier filter datapath.
// Accepts a sample (irdy/iack), steps coef_sel through NTAPS taps, aligns
// accumulate enables with MULT_LAT, then holds ordy until oack.
// Optional build macro LAB6_CTRL_PENDBUF_EN adds a 1-entry pending sample flag.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   irdy / iack       sample handshake (iack combinational), din_ld = iack
//   coef_sel, mul_en  coefficient select and multiplier operand valid
//   acc_en, acc_clr   accumulator load enable / load-instead-of-add
//   ordy / oack       result handshake
//   busy              controller not idle
//   ovf               sticky: sample offered while it could not be accepted
module lab6_ctrl
  import lab6_pkg::*;
#(
  parameter int unsigned NTAPS    = NTAPS_DEF,
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned SELW     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            irdy,
  output logic            iack,
  output logic            din_ld,
  output logic [SELW-1:0] coef_sel,
  output logic            mul_en,
  output logic            acc_en,
  output logic            acc_clr,
  output logic            ordy,
  input  logic            oack,
  output logic            busy,
  output logic            ovf
);

  localparam logic [SELW-1:0] LAST_TAP = SELW'(NTAPS - 1);

  state_e          r_state, w_nxt_state;
  logic [SELW-1:0] r_tap, w_nxt_tap;
  logic            r_mul_en, r_ordy, r_busy, r_ovf;
  logic            w_iack, w_ovf_set, w_done_ack, w_tail_empty, w_first;
`ifdef LAB6_CTRL_PENDBUF_EN
  logic            r_pend, w_nxt_pend;
`endif

  // ordy is asserted exactly in DONE, so oack elsewhere is ignored.
  assign w_done_ack = (r_state == DONE) && oack;
  assign w_first    = r_mul_en && (r_tap == '0);

  // Next-state, tap and handshake decode.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_tap   = '0;
    w_iack      = 1'b0;
    w_ovf_set   = 1'b0;
`ifdef LAB6_CTRL_PENDBUF_EN
    w_nxt_pend  = r_pend;
`endif
    case (r_state)
      IDLE: begin
        if (irdy) begin
          w_iack      = 1'b1;
          w_nxt_state = ISSUE;
        end
      end
      ISSUE: begin
        if (r_tap == LAST_TAP) w_nxt_state = DRAIN;
        else                   w_nxt_tap   = r_tap + SELW'(1);
      end
      DRAIN: begin
        if (w_tail_empty) w_nxt_state = DONE;
      end
      DONE: begin
        if (oack) w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
`ifdef LAB6_CTRL_PENDBUF_EN
    // A held sample restarts immediately; otherwise a fresh one may chain in.
    if (w_done_ack && r_pend) begin
      w_nxt_state = ISSUE;
      w_nxt_pend  = 1'b0;
    end else if (w_done_ack && irdy) begin
      w_iack      = 1'b1;
      w_nxt_state = ISSUE;
    end
    if ((r_state != IDLE) && irdy) begin
      if (r_pend) begin
        w_ovf_set = 1'b1;
      end else if (!w_done_ack) begin
        w_iack     = 1'b1;
        w_nxt_pend = 1'b1;
      end
    end
`else
    if (w_done_ack && irdy) begin
      w_iack      = 1'b1;
      w_nxt_state = ISSUE;
    end else if ((r_state != IDLE) && irdy) begin
      w_ovf_set = 1'b1;
    end
`endif
    // No sample is taken while reset is asserted.
    if (!reset) w_iack = 1'b0;
  end

  // State and registered outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_tap    <= '0;
      r_mul_en <= 1'b0;
      r_ordy   <= 1'b0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef LAB6_CTRL_PENDBUF_EN
      r_pend   <= 1'b0;
`endif
    end else begin
      r_state  <= w_nxt_state;
      r_tap    <= w_nxt_tap;
      r_mul_en <= (w_nxt_state == ISSUE);
      r_ordy   <= (w_nxt_state == DONE);
      r_busy   <= (w_nxt_state != IDLE);
      r_ovf    <= r_ovf | w_ovf_set;
`ifdef LAB6_CTRL_PENDBUF_EN
      r_pend   <= w_nxt_pend;
`endif
    end
  end

  lab6_vpipe #(
    .MULT_LAT (MULT_LAT)
  ) u_vpipe (
    .clk          (clk),
    .reset        (reset),
    .i_vld        (r_mul_en),
    .i_first      (w_first),
    .o_acc_en     (acc_en),
    .o_acc_clr    (acc_clr),
    .o_tail_empty (w_tail_empty)
  );

  assign iack     = w_iack;
  assign din_ld   = w_iack;
  assign coef_sel = r_tap;
  assign mul_en   = r_mul_en;
  assign ordy     = r_ordy;
  assign busy     = r_busy;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_lab6_ctrl.sv
// tb_lab6_ctrl: directed plus random stimulus for lab6_ctrl, checked every
// cycle against a transaction-timeline reference model (cycle index within
// the current sample's schedule).
module tb_lab6_ctrl;

  localparam int N  = 3;
  localparam int SW = 2;
`ifdef LAB6_CTRL_PENDBUF_EN
  localparam int L    = 2;
  localparam bit PEND = 1'b1;
`else
  localparam int L    = 1;
  localparam bit PEND = 1'b0;
`endif
  localparam int LT = N + L + 1;   // cycle index at which ordy appears

  logic          clk = 1'b0;
  logic          reset, irdy, oack;
  logic          iack, din_ld, mul_en, acc_en, acc_clr, ordy, busy, ovf;
  logic [SW-1:0] coef_sel;

  lab6_ctrl #(.NTAPS(N), .MULT_LAT(L), .SELW(SW)) dut (
    .clk      (clk),
    .reset    (reset),
    .irdy     (irdy),
    .iack     (iack),
    .din_ld   (din_ld),
    .coef_sel (coef_sel),
    .mul_en   (mul_en),
    .acc_en   (acc_en),
    .acc_clr  (acc_clr),
    .ordy     (ordy),
    .oack     (oack),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  // Model: m_k = 0 when idle, else cycle number n of the active sample (saturates at LT).
  int m_k    = 0;
  bit m_pend = 1'b0;
  bit m_ovf  = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (model cycle %0d)", tag, obs, exp, m_k);
    end
  endtask

  task automatic step(input bit a_irdy, input bit a_oack, input bit a_rst);
    bit e_mul, e_acc, e_clr, e_ordy, e_iack, done_ack, p0;
    int e_sel, k0;
    @(negedge clk);
    irdy  = a_irdy;
    oack  = a_oack;
    reset = a_rst;
    #1;
    e_mul    = (m_k >= 1) && (m_k <= N);
    e_sel    = e_mul ? m_k - 1 : 0;
    e_acc    = (m_k >= 1 + L) && (m_k <= N + L);
    e_clr    = (m_k == 1 + L);
    e_ordy   = (m_k == LT);
    done_ack = e_ordy && a_oack;
    if (PEND) e_iack = a_irdy && ((m_k == 0) || !m_pend);
    else      e_iack = a_irdy && ((m_k == 0) || done_ack);
    if (!a_rst) e_iack = 1'b0;
    check("iack",     8'(iack),     8'(e_iack));
    check("din_ld",   8'(din_ld),   8'(e_iack));
    check("coef_sel", 8'(coef_sel), 8'(e_sel));
    check("mul_en",   8'(mul_en),   8'(e_mul));
    check("acc_en",   8'(acc_en),   8'(e_acc));
    check("acc_clr",  8'(acc_clr),  8'(e_clr));
    check("ordy",     8'(ordy),     8'(e_ordy));
    check("busy",     8'(busy),     8'(m_k != 0));
    check("ovf",      8'(ovf),      8'(m_ovf));
    @(posedge clk);
    k0 = m_k;
    p0 = m_pend;
    if (!a_rst) begin
      m_k    = 0;
      m_pend = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      if (a_irdy && (k0 != 0) && (PEND ? p0 : !done_ack)) m_ovf = 1'b1;
      if (PEND && a_irdy && (k0 != 0) && !p0 && !done_ack) m_pend = 1'b1;
      if (k0 == 0) begin
        m_k = a_irdy ? 1 : 0;
      end else if (k0 < LT) begin
        m_k = k0 + 1;
      end else if (a_oack) begin
        if (p0) begin
          m_k    = 1;
          m_pend = 1'b0;
        end else begin
          m_k = a_irdy ? 1 : 0;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    irdy  = 1'b0;
    oack  = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then one sample, its schedule and a held result.
    step(0, 0, 1);
    step(1, 0, 1);
    repeat (LT + 10) step(0, 0, 1);
    step(0, 1, 1);
    step(0, 0, 1);

    // Back-to-back restart from DONE, then a sample offered while busy.
    step(1, 0, 1);
    repeat (LT - 1) step(0, 0, 1);
    step(1, 1, 1);
    step(0, 0, 1);
    step(1, 0, 1);
    repeat (LT) step(0, 0, 1);
    step(0, 1, 1);
    repeat (2 * LT) step(0, 0, 1);
    step(0, 1, 1);

    // A third offer while a sample is still pending (overflow either way).
    step(1, 0, 1);
    step(0, 0, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    repeat (LT) step(0, 0, 1);
    step(0, 1, 1);
    repeat (LT + 1) step(0, 0, 1);
    step(0, 1, 1);

    // Reset in the middle of a sample: nothing from it may appear afterwards.
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    repeat (LT + 2) step(0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
